idx_decode_scoreboard: RTL and testbench
========================================

Name: idx_decode_scoreboard

Overview:
- Turns binary indices back into one-hot form (M-to-N decode), the inverse of the team's N-to-M priority encoder.
- Holds a registered N-bit pending vector: an issue-side set port marks an index pending, a writeback-side clear port releases it.
- Sits between decode/issue and writeback in the NPC pipeline as a register-busy scoreboard.
- Also provides a registered one-hot echo of the last accepted set, plus a pending-bit population count.

Parameters:
- N, 8, number of tracked entries (vector width).
- M, 3, index width; M = log2(N) (ceil for non-power-of-2 N).
- ZERO_IGNORE, 1, when 1 index 0 is never marked pending (RISC-V x0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- set_valid  in  1  request to mark set_idx pending.
- set_idx  in  M  index to mark.
- set_ready  out  1  set request can be accepted this cycle.
- clr_valid  in  1  release clr_idx (always accepted).
- clr_idx  in  M  index to release.
- query_idx  in  M  index to look up.
- query_busy  out  1  pending state of query_idx, combinational from the registered vector.
- busy_vec  out  N  registered pending vector.
- busy_cnt  out  M+1  registered count of set bits in busy_vec.
- dec_valid  out  1  registered; high one cycle after an accepted set.
- dec_onehot  out  N  registered one-hot of the last accepted set_idx.

Behaviour:
- Reset (async, rst=1): busy_vec=0, busy_cnt=0, dec_valid=0, dec_onehot=0. Effective immediately; mid-operation requests are discarded.
- Decode function dec(i):
  - bit i set if i < N, else all zero.
  - With ZERO_IGNORE=1, dec(0)=0.
- set_ready = !busy_vec[set_idx] || (clr_valid && clr_idx==set_idx).
  - A release in the same cycle frees the slot.
  - Out-of-range or ignored indices give set_ready=1.
- Accepted set: set_fire = set_valid && set_ready.
- Next-state update, one cycle latency: busy_vec <= (busy_vec & ~dec(clr_idx) when clr_valid) | (dec(set_idx) when set_fire).
  - Same index set and cleared in one cycle: the set wins and the bit stays 1.
- Clear of an index that is not pending is a no-op, with no error.
- busy_cnt is registered alongside busy_vec and always equals popcount(busy_vec).
  - Derive it from the next-state vector.
  - It never exceeds N, and never counts bit 0 when ZERO_IGNORE=1.
- dec_valid <= set_fire.
- dec_onehot <= dec(set_idx) when set_fire; otherwise it holds its value.
  - dec_onehot may be 0 for an ignored or out-of-range index even when dec_valid=1.
- query_busy = busy_vec[query_idx] when query_idx < N, else 0. It reflects the registered state only, with no bypass of same-cycle set/clr.
- No internal FSM beyond the vector. All-pending (busy_cnt=N, or N-1 with ZERO_IGNORE) is legal: further sets to pending indices stall via set_ready=0.

Decomposition:
- Shared package: index width helper (clog2), ZERO_IGNORE default, and a function for one-hot decode with range check.
- One natural sub-module: dec_m_n (combinational M-to-N decoder with enable and range masking).
  - Instantiate it twice, for set and clear.
  - Popcount is an inline loop, no separate module.

Test Plan:
- Reset mid-stream: hold set_valid=1, set_idx=5, assert rst asynchronously between edges -> busy_vec, busy_cnt, dec_valid and dec_onehot go 0 without waiting for a clock edge.
- Basic set/clear: set idx 3 at cycle 1 -> cycle 2 busy_vec=8'h08, busy_cnt=1, dec_valid=1, dec_onehot=8'h08; clr idx 3 -> busy_vec=0, busy_cnt=0.
- Stall and same-cycle free: busy idx 6, set_valid idx 6 -> set_ready=0 and no change; add clr_valid idx 6 in the same cycle -> set_ready=1 and busy_vec[6] stays 1.
- ZERO_IGNORE: set idx 0 -> set_ready=1, busy_vec=0, dec_valid=1, dec_onehot=0, query_idx=0 gives query_busy=0.
- Fill: set idx 1..7 on consecutive cycles -> busy_vec=8'hFE, busy_cnt=7; clr idx 4 together with set idx 2 (pending, stalled) -> busy_vec=8'hEE, busy_cnt=6.
- Non-power-of-2 (N=6, M=3): set idx 7 -> no vector change, dec_onehot=0; query_idx=7 gives query_busy=0.

Source files
------------

// File: rtl/idx_decode_scoreboard_pkg.sv
// Shared helpers for the index decode scoreboard: index width sizing and
// the range-checked one-hot decode rule used by every decoder instance.
package idx_decode_scoreboard_pkg;

  localparam bit ZERO_IGNORE_DEFAULT = 1'b1;

  function automatic int unsigned idx_clog2(input int unsigned n);
    int unsigned w;
    w = 32'd0;
    while ((64'd1 << w) < 64'(n)) begin
      w = w + 32'd1;
    end
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

  // Bit `pos` of dec(idx): set only for an in-range index, never for x0 when ignored
  function automatic logic dec_hit(input int unsigned idx, input int unsigned pos,
                                   input int unsigned n, input logic zero_ignore);
    logic hit;
    if (idx >= n) begin
      hit = 1'b0;
    end else if (zero_ignore && (idx == 32'd0)) begin
      hit = 1'b0;
    end else begin
      hit = (idx == pos);
    end
    return hit;
  endfunction

endpackage

// File: rtl/idx_decode_scoreboard_dec_m_n.sv
// Combinational M-to-N one-hot decoder with enable, range masking and
// optional suppression of index 0.
module dec_m_n
  import idx_decode_scoreboard_pkg::*;
#(
  parameter int N           = 8,
  parameter int M           = 3,
  parameter bit ZERO_IGNORE = ZERO_IGNORE_DEFAULT
) (
  input  logic         en,
  input  logic [M-1:0] idx,
  output logic [N-1:0] onehot
);

  // Per-bit decode gated by the enable
  always_comb begin
    onehot = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (en) begin
        onehot[i] = dec_hit(32'(idx), 32'(i), 32'(N), ZERO_IGNORE);
      end else begin
        onehot[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/idx_decode_scoreboard.sv
// Register-busy scoreboard: issue-side set, writeback-side clear, registered
// pending vector with population count and a one-hot echo of the last set.
module idx_decode_scoreboard
  import idx_decode_scoreboard_pkg::*;
#(
  parameter int N           = 8,
  parameter int M           = idx_clog2(N),
  parameter bit ZERO_IGNORE = ZERO_IGNORE_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         set_valid,
  input  logic [M-1:0] set_idx,
  output logic         set_ready,
  input  logic         clr_valid,
  input  logic [M-1:0] clr_idx,
  input  logic [M-1:0] query_idx,
  output logic         query_busy,
  output logic [N-1:0] busy_vec,
  output logic [M:0]   busy_cnt,
  output logic         dec_valid,
  output logic [N-1:0] dec_onehot
);

  logic [N-1:0] busy_vec_r;
  logic [M:0]   busy_cnt_r;
  logic         dec_valid_r;
  logic [N-1:0] dec_onehot_r;

  logic         set_pend_s;
  logic         query_hit_s;
  logic         same_idx_s;
  logic         set_ready_s;
  logic         set_fire_s;
  logic [N-1:0] set_mask_s;
  logic [N-1:0] clr_mask_s;
  logic [N-1:0] busy_next_s;
  logic [M:0]   cnt_next_s;

  // Registered-state lookups; out-of-range indices match no bit and read as idle
  always_comb begin
    set_pend_s  = 1'b0;
    query_hit_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      set_pend_s  = set_pend_s  | ((set_idx   == M'(i)) & busy_vec_r[i]);
      query_hit_s = query_hit_s | ((query_idx == M'(i)) & busy_vec_r[i]);
    end
  end

  assign same_idx_s  = clr_valid & (clr_idx == set_idx);
  assign set_ready_s = ~set_pend_s | same_idx_s;
  assign set_fire_s  = set_valid & set_ready_s;

  dec_m_n #(.N(N), .M(M), .ZERO_IGNORE(ZERO_IGNORE)) u_dec_set (
    .en     (set_fire_s),
    .idx    (set_idx),
    .onehot (set_mask_s)
  );

  dec_m_n #(.N(N), .M(M), .ZERO_IGNORE(ZERO_IGNORE)) u_dec_clr (
    .en     (clr_valid),
    .idx    (clr_idx),
    .onehot (clr_mask_s)
  );

  // OR-ing the set mask after the clear makes a same-index set win
  assign busy_next_s = (busy_vec_r & ~clr_mask_s) | set_mask_s;

  // Population count of the next-state vector so the count lands with it
  always_comb begin
    cnt_next_s = {(M+1){1'b0}};
    for (int i = 0; i < N; i++) begin
      cnt_next_s = cnt_next_s + {{M{1'b0}}, busy_next_s[i]};
    end
  end

  // State registers; the one-hot echo holds between accepted sets
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_vec_r   <= {N{1'b0}};
      busy_cnt_r   <= {(M+1){1'b0}};
      dec_valid_r  <= 1'b0;
      dec_onehot_r <= {N{1'b0}};
    end else begin
      busy_vec_r   <= busy_next_s;
      busy_cnt_r   <= cnt_next_s;
      dec_valid_r  <= set_fire_s;
      if (set_fire_s) begin
        dec_onehot_r <= set_mask_s;
      end else begin
        dec_onehot_r <= dec_onehot_r;
      end
    end
  end

  assign set_ready  = set_ready_s;
  assign query_busy = query_hit_s;
  assign busy_vec   = busy_vec_r;
  assign busy_cnt   = busy_cnt_r;
  assign dec_valid  = dec_valid_r;
  assign dec_onehot = dec_onehot_r;

endmodule

// File: tb/tb_idx_decode_scoreboard.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// per-register pending model, on an N=8 and an N=6 instance.
module tb_idx_decode_scoreboard;

  logic       clk;
  logic       rst;
  logic       set_valid, clr_valid, set_ready, query_busy, dec_valid;
  logic [2:0] set_idx, clr_idx, query_idx;
  logic [7:0] busy_vec, dec_onehot;
  logic [3:0] busy_cnt;

  logic       s6_set_valid, s6_clr_valid, s6_set_ready, s6_query_busy, s6_dec_valid;
  logic [2:0] s6_set_idx, s6_clr_idx, s6_query_idx;
  logic [5:0] s6_busy_vec, s6_dec_onehot;
  logic [3:0] s6_busy_cnt;

  int errors = 0;
  int checks = 0;

  // reference model for the N=8 instance
  bit pend[8];
  int m_onehot;
  bit m_valid;

  idx_decode_scoreboard #(.N(8), .M(3), .ZERO_IGNORE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .set_valid(set_valid), .set_idx(set_idx), .set_ready(set_ready),
    .clr_valid(clr_valid), .clr_idx(clr_idx),
    .query_idx(query_idx), .query_busy(query_busy),
    .busy_vec(busy_vec), .busy_cnt(busy_cnt),
    .dec_valid(dec_valid), .dec_onehot(dec_onehot)
  );

  idx_decode_scoreboard #(.N(6), .M(3), .ZERO_IGNORE(1'b1)) dut6 (
    .clk(clk), .rst(rst),
    .set_valid(s6_set_valid), .set_idx(s6_set_idx), .set_ready(s6_set_ready),
    .clr_valid(s6_clr_valid), .clr_idx(s6_clr_idx),
    .query_idx(s6_query_idx), .query_busy(s6_query_busy),
    .busy_vec(s6_busy_vec), .busy_cnt(s6_busy_cnt),
    .dec_valid(s6_dec_valid), .dec_onehot(s6_dec_onehot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit sv, input int si, input bit cv, input int ci, input int qi);
    set_valid = sv;
    set_idx   = 3'(si);
    clr_valid = cv;
    clr_idx   = 3'(ci);
    query_idx = 3'(qi);
  endtask

  function automatic bit decodable(input int i, input int n);
    return (i < n) && (i != 0);
  endfunction

  function automatic int model_vec();
    int v = 0;
    for (int i = 0; i < 8; i++) if (pend[i]) v += (1 << i);
    return v;
  endfunction

  function automatic int model_cnt();
    int c = 0;
    for (int i = 0; i < 8; i++) if (pend[i]) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) pend[i] = 1'b0;
    m_onehot = 0;
    m_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drv(0, 0, 0, 0, 0);
    s6_set_valid = 1'b0; s6_set_idx = 3'd0; s6_clr_valid = 1'b0;
    s6_clr_idx = 3'd0; s6_query_idx = 3'd0;
    tick(); tick();
    checks++; if (busy_vec !== 8'h00) begin errors++; $display("FAIL reset_vec: got %h want 00", busy_vec); end
    checks++; if (busy_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", busy_cnt); end
    checks++; if (dec_valid !== 1'b0 || dec_onehot !== 8'h00) begin errors++; $display("FAIL reset_dec: got %b/%h want 0/00", dec_valid, dec_onehot); end
    rst = 1'b0;
    drv(1, 5, 0, 0, 5);
    tick();
    checks++; if (busy_vec !== 8'h20) begin errors++; $display("FAIL pre_reset_set: got %h want 20", busy_vec); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy_vec !== 8'h00 || busy_cnt !== 4'd0) begin errors++; $display("FAIL async_reset_vec: got %h/%0d want 00/0", busy_vec, busy_cnt); end
    checks++; if (dec_valid !== 1'b0 || dec_onehot !== 8'h00) begin errors++; $display("FAIL async_reset_dec: got %b/%h want 0/00", dec_valid, dec_onehot); end
    tick();
    drv(0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    tick();
    checks++; if (busy_vec !== 8'h00) begin errors++; $display("FAIL post_reset_vec: got %h want 00", busy_vec); end
  endtask

  task automatic test_basic();
    drv(1, 3, 0, 0, 3);
    #1;
    checks++; if (set_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b want 1", set_ready); end
    checks++; if (query_busy !== 1'b0) begin errors++; $display("FAIL basic_query_pre: got %b want 0", query_busy); end
    tick();
    checks++; if (busy_vec !== 8'h08 || busy_cnt !== 4'd1) begin errors++; $display("FAIL basic_set: got %h/%0d want 08/1", busy_vec, busy_cnt); end
    checks++; if (dec_valid !== 1'b1 || dec_onehot !== 8'h08) begin errors++; $display("FAIL basic_dec: got %b/%h want 1/08", dec_valid, dec_onehot); end
    checks++; if (query_busy !== 1'b1) begin errors++; $display("FAIL basic_query: got %b want 1", query_busy); end
    drv(0, 0, 1, 3, 3);
    tick();
    checks++; if (busy_vec !== 8'h00 || busy_cnt !== 4'd0) begin errors++; $display("FAIL basic_clr: got %h/%0d want 00/0", busy_vec, busy_cnt); end
    checks++; if (dec_valid !== 1'b0 || dec_onehot !== 8'h08) begin errors++; $display("FAIL basic_hold: got %b/%h want 0/08", dec_valid, dec_onehot); end
  endtask

  task automatic test_stall();
    drv(1, 6, 0, 0, 6);
    tick();
    drv(1, 6, 0, 0, 6);
    #1;
    checks++; if (set_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b want 0", set_ready); end
    tick();
    checks++; if (busy_vec !== 8'h40 || dec_valid !== 1'b0) begin errors++; $display("FAIL stall_hold: got %h/%b want 40/0", busy_vec, dec_valid); end
    drv(1, 6, 1, 6, 6);
    #1;
    checks++; if (set_ready !== 1'b1) begin errors++; $display("FAIL free_ready: got %b want 1", set_ready); end
    tick();
    checks++; if (busy_vec !== 8'h40 || busy_cnt !== 4'd1) begin errors++; $display("FAIL set_wins: got %h/%0d want 40/1", busy_vec, busy_cnt); end
    checks++; if (dec_valid !== 1'b1 || dec_onehot !== 8'h40) begin errors++; $display("FAIL set_wins_dec: got %b/%h want 1/40", dec_valid, dec_onehot); end
    drv(0, 0, 1, 6, 0);
    tick();
    drv(0, 0, 1, 2, 0);
    tick();
    checks++; if (busy_vec !== 8'h00) begin errors++; $display("FAIL clr_idle_noop: got %h want 00", busy_vec); end
  endtask

  task automatic test_zero_ignore();
    drv(1, 0, 0, 0, 0);
    #1;
    checks++; if (set_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b want 1", set_ready); end
    tick();
    checks++; if (busy_vec !== 8'h00 || busy_cnt !== 4'd0) begin errors++; $display("FAIL zero_vec: got %h/%0d want 00/0", busy_vec, busy_cnt); end
    checks++; if (dec_valid !== 1'b1 || dec_onehot !== 8'h00) begin errors++; $display("FAIL zero_dec: got %b/%h want 1/00", dec_valid, dec_onehot); end
    checks++; if (query_busy !== 1'b0) begin errors++; $display("FAIL zero_query: got %b want 0", query_busy); end
    drv(0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_fill();
    for (int i = 1; i < 8; i++) begin
      drv(1, i, 0, 0, 0);
      tick();
    end
    checks++; if (busy_vec !== 8'hFE || busy_cnt !== 4'd7) begin errors++; $display("FAIL fill_vec: got %h/%0d want FE/7", busy_vec, busy_cnt); end
    drv(1, 2, 1, 4, 7);
    #1;
    checks++; if (set_ready !== 1'b0) begin errors++; $display("FAIL fill_stall: got %b want 0", set_ready); end
    checks++; if (query_busy !== 1'b1) begin errors++; $display("FAIL fill_query7: got %b want 1", query_busy); end
    tick();
    checks++; if (busy_vec !== 8'hEE || busy_cnt !== 4'd6) begin errors++; $display("FAIL fill_clr: got %h/%0d want EE/6", busy_vec, busy_cnt); end
    drv(0, 0, 0, 0, 4);
    #1;
    checks++; if (query_busy !== 1'b0) begin errors++; $display("FAIL fill_query4: got %b want 0", query_busy); end
  endtask

  task automatic test_nonpow2();
    s6_set_valid = 1'b1; s6_set_idx = 3'd5; s6_query_idx = 3'd5;
    tick();
    checks++; if (s6_busy_vec !== 6'h20 || s6_query_busy !== 1'b1) begin errors++; $display("FAIL n6_set5: got %h/%b want 20/1", s6_busy_vec, s6_query_busy); end
    s6_set_idx = 3'd7; s6_query_idx = 3'd7;
    #1;
    checks++; if (s6_set_ready !== 1'b1) begin errors++; $display("FAIL n6_ready7: got %b want 1", s6_set_ready); end
    tick();
    checks++; if (s6_busy_vec !== 6'h20 || s6_busy_cnt !== 4'd1) begin errors++; $display("FAIL n6_set7: got %h/%0d want 20/1", s6_busy_vec, s6_busy_cnt); end
    checks++; if (s6_dec_valid !== 1'b1 || s6_dec_onehot !== 6'h00) begin errors++; $display("FAIL n6_dec7: got %b/%h want 1/00", s6_dec_valid, s6_dec_onehot); end
    checks++; if (s6_query_busy !== 1'b0) begin errors++; $display("FAIL n6_query7: got %b want 0", s6_query_busy); end
    s6_set_valid = 1'b0; s6_clr_valid = 1'b1; s6_clr_idx = 3'd5;
    tick();
    s6_clr_valid = 1'b0;
    checks++; if (s6_busy_vec !== 6'h00 || s6_busy_cnt !== 4'd0) begin errors++; $display("FAIL n6_clr5: got %h/%0d want 00/0", s6_busy_vec, s6_busy_cnt); end
  endtask

  task automatic test_random();
    bit sv, cv, exp_ready, fire;
    int si, ci, qi;
    rst = 1'b1;
    drv(0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    model_reset();
    tick();
    for (int n = 0; n < 400; n++) begin
      sv = ($urandom_range(0, 3) != 0);
      cv = ($urandom_range(0, 2) == 0);
      si = $urandom_range(0, 7);
      ci = $urandom_range(0, 7);
      qi = $urandom_range(0, 7);
      drv(sv, si, cv, ci, qi);
      #1;
      exp_ready = !pend[si] || (cv && ci == si);
      fire = sv && exp_ready;
      checks++; if (set_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, set_ready, exp_ready); end
      checks++; if (query_busy !== pend[qi]) begin errors++; $display("FAIL rnd_query[%0d]: got %b want %b", n, query_busy, pend[qi]); end
      tick();
      if (cv) pend[ci] = 1'b0;
      if (fire && decodable(si, 8)) pend[si] = 1'b1;
      if (fire) m_onehot = decodable(si, 8) ? (1 << si) : 0;
      m_valid = fire;
      checks++; if (busy_vec !== 8'(model_vec()) || busy_cnt !== 4'(model_cnt())) begin errors++; $display("FAIL rnd_vec[%0d]: got %h/%0d want %h/%0d", n, busy_vec, busy_cnt, model_vec(), model_cnt()); end
      checks++; if (dec_valid !== m_valid || dec_onehot !== 8'(m_onehot)) begin errors++; $display("FAIL rnd_dec[%0d]: got %b/%h want %b/%h", n, dec_valid, dec_onehot, m_valid, m_onehot); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_ignore();
    test_fill();
    test_nonpow2();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
